// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store sequencer: FSM states, RV32I
// funct3 encodings, byte-lane strobe generation and access legality.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  function automatic logic [3:0] byte_lanes(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  // Unsigned variants only exist for loads; size must also be naturally aligned.
  function automatic logic access_ok(input logic is_store, input logic [2:0] f3,
                                     input logic [1:0] off);
    case (f3)
      F3_B:         return 1'b1;
      F3_H:         return !off[0];
      F3_W:         return off == 2'b00;
      F3_BU:        return !is_store;
      F3_HU:        return !is_store && !off[0];
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: selects the byte/half lane from the read word
// and sign- or zero-extends it according to funct3. Zero latency, no handshake.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data_o = {24'd0, byte_sel};
      F3_HU:   data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one outstanding req/ack memory access, stall held from accept to ack.
// Latency >= 2 stall cycles (accept, then ack in BUSY); bus timeout after TIMEOUT cycles without ack.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_error
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ldata_q, ldata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        lvld_q, lvld_d, mis_q, mis_d, berr_q, berr_d;
  logic        access, legal;
  logic [31:0] aligned, steered;

  load_align u_align (
    .rdata_i  (mem_rdata),
    .off_i    (off_q),
    .funct3_i (f3_q),
    .data_o   (aligned)
  );

  assign access = read_enable | write_enable;
  assign legal  = access_ok(write_enable, funct3, addr[1:0]);

  always_comb begin
    case (funct3[1:0])
      2'b00:   steered = {4{store_data[7:0]}};
      2'b01:   steered = {2{store_data[15:0]}};
      default: steered = store_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    f3_d    = f3_q;
    off_d   = off_q;
    ldata_d = ldata_q;
    lvld_d  = 1'b0;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && legal) begin
          req_d   = 1'b1;
          we_d    = write_enable;
          addr_d  = {addr[31:2], 2'b00};
          wdata_d = write_enable ? steered : 32'd0;
          wstrb_d = write_enable ? byte_lanes(funct3[1:0], addr[1:0]) : 4'd0;
          f3_d    = funct3;
          off_d   = addr[1:0];
          cnt_d   = '0;
          state_d = S_BUSY;
        end else if (access) begin
          mis_d = 1'b1;
        end
      end
      S_BUSY: begin
        // Ack is checked first so an ack on the final counted cycle still completes cleanly.
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          if (!we_q) begin
            ldata_d = aligned;
            lvld_d  = 1'b1;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          berr_d  = 1'b1;
          ldata_d = 32'd0;
          lvld_d  = !we_q;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      ldata_q <= 32'd0;
      lvld_q  <= 1'b0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      ldata_q <= ldata_d;
      lvld_q  <= lvld_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign stall      = !rst && ((state_q == S_IDLE && access && legal) || state_q == S_BUSY);
  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;
  assign load_data  = ldata_q;
  assign load_valid = lvld_q;
  assign misaligned = mis_q;
  assign bus_error  = berr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a scoreboard of expected transactions.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read_enable = 1'b0, write_enable = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0, store_data = 32'd0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] load_data;
  logic        load_valid, stall, misaligned, bus_error;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] ldata;
    logic        berr;
    int          stalls;
  } exp_t;

  exp_t sb[$];

  lsu_ctrl #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .stall        (stall),
    .misaligned   (misaligned),
    .bus_error    (bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] ws, input logic [31:0] ld, input logic be,
                              input int st);
    exp_t e;
    e.we = we; e.addr = a; e.wdata = wd; e.wstrb = ws;
    e.ldata = ld; e.berr = be; e.stalls = st;
    return e;
  endfunction

  // ack_at = cycle (counted from the accept cycle) in which mem_ack is driven; 0 = never.
  task automatic run_acc(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input int ack_at,
                         input logic [31:0] rd, input exp_t e);
    exp_t x;
    int   stalls = 0;
    bit   seen = 0;
    bit   done = 0;
    sb.push_back(e);
    @(negedge clk);
    read_enable = !we; write_enable = we; funct3 = f3; addr = a; store_data = sd;
    #1;
    if (stall) stalls++;
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(negedge clk);
      read_enable = 1'b0; write_enable = 1'b0;
      mem_ack = (cyc == ack_at); mem_rdata = rd;
      #1;
      if (mem_req && !seen) begin
        seen = 1;
        x = sb[0];
        chk({tag, ".mem_addr"}, mem_addr, x.addr);
        chk({tag, ".mem_we"}, mem_we, x.we);
        chk({tag, ".mem_wstrb"}, mem_wstrb, x.wstrb);
        if (x.we) chk({tag, ".mem_wdata"}, mem_wdata, x.wdata);
      end
      if (seen && !mem_req) begin
        done = 1;
        x = sb.pop_front();
        chk({tag, ".stall_cycles"}, stalls, x.stalls);
        chk({tag, ".stall_done"}, stall, 1'b0);
        chk({tag, ".load_valid"}, load_valid, !x.we);
        chk({tag, ".bus_error"}, bus_error, x.berr);
        if (!x.we) chk({tag, ".load_data"}, load_data, x.ldata);
      end else if (stall) begin
        stalls++;
      end
    end
    mem_ack = 1'b0;
    n_chk++;
    assert (done) else begin
      n_fail++;
      $error("FAIL %s.complete: observed no completion within 40 cycles, expected completion", tag);
      if (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  task automatic run_mis(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] a);
    @(negedge clk);
    read_enable = !we; write_enable = we; funct3 = f3; addr = a; store_data = 32'h5A5A5A5A;
    #1 chk({tag, ".stall"}, stall, 1'b0);
    @(negedge clk);
    read_enable = 1'b0; write_enable = 1'b0;
    #1;
    chk({tag, ".misaligned"}, misaligned, 1'b1);
    chk({tag, ".mem_req"}, mem_req, 1'b0);
    chk({tag, ".stall1"}, stall, 1'b0);
    @(negedge clk);
    #1;
    chk({tag, ".mis_pulse_end"}, misaligned, 1'b0);
    chk({tag, ".mem_req2"}, mem_req, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst.mem_req", mem_req, 1'b0);
    chk("rst.mem_we", mem_we, 1'b0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    chk("rst.mem_wstrb", mem_wstrb, 4'd0);
    chk("rst.load_data", load_data, 32'd0);
    chk("rst.load_valid", load_valid, 1'b0);
    chk("rst.misaligned", misaligned, 1'b0);
    chk("rst.bus_error", bus_error, 1'b0);
    read_enable = 1'b1;
    #1 chk("rst.stall_forced", stall, 1'b0);
    read_enable = 1'b0;
    rst = 1'b0;

    run_acc("lw",  1'b0, 3'd2, 32'h100, 32'd0, 3, 32'hDEADBEEF,
            mk(1'b0, 32'h100, 32'd0, 4'h0, 32'hDEADBEEF, 1'b0, 4));
    run_acc("lb",  1'b0, 3'd0, 32'h203, 32'd0, 1, 32'h80112233,
            mk(1'b0, 32'h200, 32'd0, 4'h0, 32'hFFFFFF80, 1'b0, 2));
    run_acc("lbu", 1'b0, 3'd4, 32'h203, 32'd0, 1, 32'h80112233,
            mk(1'b0, 32'h200, 32'd0, 4'h0, 32'h00000080, 1'b0, 2));
    run_acc("lh",  1'b0, 3'd1, 32'h202, 32'd0, 2, 32'h80112233,
            mk(1'b0, 32'h200, 32'd0, 4'h0, 32'hFFFF8011, 1'b0, 3));
    run_acc("lhu", 1'b0, 3'd5, 32'h200, 32'd0, 1, 32'h80118233,
            mk(1'b0, 32'h200, 32'd0, 4'h0, 32'h00008233, 1'b0, 2));
    run_acc("sb",  1'b1, 3'd0, 32'h11, 32'h000000A5, 1, 32'd0,
            mk(1'b1, 32'h10, 32'hA5A5A5A5, 4'b0010, 32'd0, 1'b0, 2));
    run_acc("sh",  1'b1, 3'd1, 32'h12, 32'h0000BEEF, 2, 32'd0,
            mk(1'b1, 32'h10, 32'hBEEFBEEF, 4'b1100, 32'd0, 1'b0, 3));
    run_acc("sw",  1'b1, 3'd2, 32'h20, 32'h12345678, 1, 32'd0,
            mk(1'b1, 32'h20, 32'h12345678, 4'b1111, 32'd0, 1'b0, 2));

    run_mis("mis_lw", 1'b0, 3'd2, 32'h102);
    run_mis("mis_f3", 1'b0, 3'd3, 32'h100);
    run_mis("mis_sh", 1'b1, 3'd1, 32'h13);
    run_mis("mis_sbu", 1'b1, 3'd4, 32'h10);

    run_acc("tmo_lw", 1'b0, 3'd2, 32'h40, 32'd0, 0, 32'hFFFFFFFF,
            mk(1'b0, 32'h40, 32'd0, 4'h0, 32'd0, 1'b1, 17));
    run_acc("ack16",  1'b0, 3'd2, 32'h44, 32'd0, 16, 32'hCAFEF00D,
            mk(1'b0, 32'h44, 32'd0, 4'h0, 32'hCAFEF00D, 1'b0, 17));
    run_acc("tmo_sw", 1'b1, 3'd2, 32'h48, 32'h0BADF00D, 0, 32'd0,
            mk(1'b1, 32'h48, 32'h0BADF00D, 4'b1111, 32'd0, 1'b1, 17));

    // Reset while a load is outstanding, then a stray ack.
    @(negedge clk);
    read_enable = 1'b1; funct3 = 3'd2; addr = 32'h300;
    @(negedge clk);
    read_enable = 1'b0;
    @(negedge clk);
    #1 chk("rstbusy.mem_req_before", mem_req, 1'b1);
    rst = 1'b1;
    #1 chk("rstbusy.stall", stall, 1'b0);
    @(negedge clk);
    #1 chk("rstbusy.mem_req_after", mem_req, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("stray.load_valid", load_valid, 1'b0);
    chk("stray.stall", stall, 1'b0);
    chk("stray.load_data", load_data, 32'd0);

    run_acc("recover", 1'b0, 3'd2, 32'h304, 32'd0, 1, 32'h0F0F0F0F,
            mk(1'b0, 32'h304, 32'd0, 4'h0, 32'h0F0F0F0F, 1'b0, 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the execute stage and a handshaked data memory port. Takes decoded load/store requests (`read_enable`/`write_enable`, funct3, effective address, store data), drives a single-outstanding req/ack memory transaction, and stalls the pipeline until it completes. Handles byte/half/word lane steering, sign/zero extension, misalignment detection and a bus timeout.

## Interface
- `TIMEOUT`, default 16: max cycles in BUSY without `mem_ack` before a bus error; must be ≥2.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high.
- `read_enable`  in  1  load in execute.
- `write_enable`  in  1  store in execute; never high together with `read_enable`.
- `funct3`  in  3  access size/sign (RV32I encoding).
- `addr`  in  32  effective address (ALU out).
- `store_data`  in  32  rs2 value.
- `mem_req`  out  1  transaction request, held until ack.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word-aligned address (`addr & ~3`).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_wstrb`  out  4  byte enables; 0 for reads.
- `mem_ack`  in  1  one-cycle completion; `mem_rdata` valid same cycle.
- `mem_rdata`  in  32  read word.
- `load_data`  out  32  aligned, extended load result.
- `load_valid`  out  1  one-cycle pulse, `load_data` valid.
- `stall`  out  1  hold fetch/decode/execute.
- `misaligned`  out  1  one-cycle fault pulse, no bus access.
- `bus_error`  out  1  one-cycle timeout pulse.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: access = `read_enable|write_enable`. Legal funct3: loads 0,1,2,4,5; stores 0,1,2. Fault if illegal funct3, half with `addr[0]`=1, word with `addr[1:0]`≠0 → `misaligned`=1 next cycle, stay IDLE, no stall.
- IDLE legal access: `stall`=1 combinationally; register `mem_addr`, `mem_we`, `mem_wdata`, `mem_wstrb`, `funct3`, `addr[1:0]`; set `mem_req`; → BUSY.
- Store steering: SB wdata = byte×4, wstrb = 4'b0001<<addr[1:0]; SH wdata = half×2, wstrb = 4'b0011<<{addr[1],1'b0}; SW wdata = data, wstrb = 4'b1111.
- BUSY: `stall`=1, `mem_req`=1, outputs stable. Cycle counter increments. On `mem_ack`: capture extended `mem_rdata` into `load_data` (loads only), clear `mem_req`, → DONE. Counter reaches TIMEOUT without ack: `bus_error`=1, `load_data`=0, clear `mem_req`, → DONE.
- Load extraction: byte at `addr[1:0]`, half at `addr[1]`; funct3 0/1 sign-extend, 4/5 zero-extend, 2 full word.
- DONE: `stall`=0 (instruction retires), `load_valid`=1 for loads (also on timeout, data 0); inputs ignored; → IDLE.
- `mem_ack` outside BUSY ignored. Ack in the same cycle as timeout expiry: ack wins, no `bus_error`.

## Timing
- Reset: state IDLE, counter 0; all registered outputs 0 (`mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_wstrb`, `load_data`, `load_valid`, `misaligned`, `bus_error`); `stall` forced 0 while `rst`.
- Access seen cycle 0 → `mem_req` high cycle 1; ack at cycle k≥1 → DONE/`load_valid` cycle k+1; `stall` high cycles 0..k. Minimum: 2 stall cycles.
- Timeout: ack absent cycles 1..TIMEOUT → `bus_error` and DONE at cycle TIMEOUT+1.
- Back-to-back accesses: next accepted in IDLE the cycle after DONE.
- Reset mid-BUSY: `mem_req` low at next edge; outstanding ack dropped.

## Structure
- `lsu_pkg`: FSM state enum; funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU); byte-lane helper function.
- Sub-module `load_align`: combinational rdata + offset + funct3 → extended 32-bit result.

## Test plan
- LW addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF → mem_addr 0x100, wstrb 0, stall 4 cycles, load_data 0xDEADBEEF with load_valid.
- LB addr 0x203, rdata 0x80112233 → 0xFFFFFF80; LBU same → 0x00000080; LH addr 0x202 → 0xFFFF8011.
- SB addr 0x11, data 0x000000A5 → mem_addr 0x10, wdata 0xA5A5A5A5, wstrb 4'b0010, mem_we 1; SH addr 0x12 → wstrb 4'b1100.
- LW addr 0x102 → misaligned pulse, mem_req never high, stall 0; funct3 3 load → same.
- No ack, TIMEOUT 16 → bus_error at cycle 17, load_data 0, load_valid 1; ack at cycle 16 → no error.
- rst asserted in BUSY → mem_req 0 next cycle, stall 0, later stray ack ignored.
